// File: rtl/adaptive_speed_pkg.sv
// Shared definitions for the adaptive speed controller: state codes and
// the decode of a state into its drive commands.
package adaptive_speed_pkg;

    typedef enum logic [2:0] {
        ST_STOP       = 3'd0,
        ST_ACCELERATE = 3'd1,
        ST_CRUISE     = 3'd2,
        ST_DECELERATE = 3'd3,
        ST_EMERGENCY  = 3'd4
    } state_t;

    typedef struct packed {
        logic accelerate;
        logic brake;
        logic emergency;
    } drive_t;

    localparam drive_t DRIVE_IDLE  = '{accelerate: 1'b0, brake: 1'b0, emergency: 1'b0};
    localparam drive_t DRIVE_ACCEL = '{accelerate: 1'b1, brake: 1'b0, emergency: 1'b0};
    localparam drive_t DRIVE_BRAKE = '{accelerate: 1'b0, brake: 1'b1, emergency: 1'b0};
    localparam drive_t DRIVE_EMERG = '{accelerate: 1'b0, brake: 1'b1, emergency: 1'b1};

    function automatic drive_t decode_drive(input state_t s);
        drive_t d;
        case (s)
            ST_ACCELERATE: d = DRIVE_ACCEL;
            ST_DECELERATE: d = DRIVE_BRAKE;
            ST_EMERGENCY:  d = DRIVE_EMERG;
            default:       d = DRIVE_IDLE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/adaptive_speed_ctrl_stop_hold_counter.sv
// Counts consecutive zero-speed cycles spent in STOP, saturating at
// STOP_HOLD_CYCLES; any other cycle clears it.
module stop_hold_counter #(
    parameter int unsigned STOP_HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    output logic full
);

    localparam int unsigned CNT_W = $clog2(STOP_HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STOP_HOLD_CYCLES);

    logic [CNT_W-1:0] hold_cnt;

    // Saturating up-count while enabled, clear otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (!count_en) begin
            hold_cnt <= '0;
        end else if (hold_cnt != CNT_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign full = (hold_cnt == CNT_MAX);

endmodule

// File: rtl/adaptive_speed_ctrl.sv
// Adaptive cruise speed controller: five-state FSM choosing between
// accelerate, cruise, decelerate and emergency braking, with a door
// unlock after the car has been stationary in STOP for a hold period.
module adaptive_speed_ctrl
    import adaptive_speed_pkg::*;
#(
    parameter int unsigned SPEED_W          = 8,
    parameter int unsigned DIST_W           = 7,
    parameter int unsigned MIN_DISTANCE     = 40,
    parameter int unsigned BRAKE_DISTANCE   = 10,
    parameter int unsigned HYST             = 2,
    parameter int unsigned STOP_HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [SPEED_W-1:0] speed_limit,
    input  logic [SPEED_W-1:0] car_speed,
    input  logic [DIST_W-1:0]  leading_distance,
    output logic               unlock_doors,
    output logic               accelerate_car,
    output logic               brake_car,
    output logic               emergency_brake,
    output logic [2:0]         state
);

    localparam logic [DIST_W-1:0]  MIN_D  = DIST_W'(MIN_DISTANCE);
    localparam logic [DIST_W-1:0]  BRK_D  = DIST_W'(BRAKE_DISTANCE);
    localparam logic [SPEED_W-1:0] HYST_V = SPEED_W'(HYST);

    state_t             cs;
    state_t             ns;
    logic [SPEED_W-1:0] lo;
    logic               danger;
    logic               too_close;
    logic               over_limit;
    logic               stopped;
    logic               below_band;
    logic               in_band;
    logic               slow_down;
    logic               hold_en;
    logic               hold_full;
    drive_t             drv;

    // Band floor saturates at zero instead of wrapping for small limits.
    always_comb begin
        lo = '0;
        if (speed_limit >= HYST_V) begin
            lo = speed_limit - HYST_V;
        end
    end

    assign danger     = (leading_distance < BRK_D);
    assign too_close  = (leading_distance < MIN_D);
    assign over_limit = (car_speed > speed_limit);
    assign stopped    = (car_speed == '0);
    assign below_band = (car_speed < lo);
    assign in_band    = !below_band && !over_limit;
    assign slow_down  = !enable || too_close || over_limit;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs <= ST_STOP;
        end else begin
            cs <= ns;
        end
    end

    // Next-state selection; EMERGENCY is left only once the car is stationary.
    always_comb begin
        ns = cs;
        case (cs)
            ST_STOP: begin
                if (enable && !too_close) ns = ST_ACCELERATE;
            end
            ST_ACCELERATE, ST_CRUISE, ST_DECELERATE: begin
                if (danger) begin
                    ns = ST_EMERGENCY;
                end else if (slow_down) begin
                    ns = (cs == ST_DECELERATE && stopped) ? ST_STOP : ST_DECELERATE;
                end else begin
                    case (cs)
                        ST_ACCELERATE: if (in_band) ns = ST_CRUISE;
                        ST_CRUISE:     if (below_band) ns = ST_ACCELERATE;
                        default: begin
                            if (stopped)         ns = ST_STOP;
                            else if (below_band) ns = ST_ACCELERATE;
                            else if (in_band)    ns = ST_CRUISE;
                        end
                    endcase
                end
            end
            ST_EMERGENCY: begin
                if (stopped) ns = ST_STOP;
            end
            default: ns = ST_STOP;
        endcase
    end

    assign hold_en = (cs == ST_STOP) && stopped;

    stop_hold_counter #(
        .STOP_HOLD_CYCLES(STOP_HOLD_CYCLES)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .count_en(hold_en),
        .full    (hold_full)
    );

    assign drv             = decode_drive(cs);
    assign accelerate_car  = drv.accelerate;
    assign brake_car       = drv.brake;
    assign emergency_brake = drv.emergency;
    assign unlock_doors    = (cs == ST_STOP) && hold_full;
    assign state           = cs;

endmodule

// File: tb/tb_adaptive_speed_ctrl.sv
// Scoreboard bench for adaptive_speed_ctrl: the driver pushes the expected
// post-edge outputs for each driven cycle; the monitor pops and compares
// shortly after every rising edge.
module tb_adaptive_speed_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] speed_limit = '0;
    logic [7:0] car_speed = '0;
    logic [6:0] leading_distance = '0;
    logic       unlock_doors;
    logic       accelerate_car;
    logic       brake_car;
    logic       emergency_brake;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0] v;
        string      name;
    } exp_t;

    exp_t sb_q[$];

    adaptive_speed_ctrl #(
        .SPEED_W         (8),
        .DIST_W          (7),
        .MIN_DISTANCE    (40),
        .BRAKE_DISTANCE  (10),
        .HYST            (2),
        .STOP_HOLD_CYCLES(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .speed_limit     (speed_limit),
        .car_speed       (car_speed),
        .leading_distance(leading_distance),
        .unlock_doors    (unlock_doors),
        .accelerate_car  (accelerate_car),
        .brake_car       (brake_car),
        .emergency_brake (emergency_brake),
        .state           (state)
    );

    always #5 clk = ~clk;

    // {state, unlock, accelerate, brake, emergency}
    function automatic logic [6:0] exp_vec(input logic [2:0] st, input logic u);
        return {st, u, (st == 3'd1), (st == 3'd3 || st == 3'd4), (st == 3'd4)};
    endfunction

    function automatic logic [6:0] out_vec();
        return {state, unlock_doors, accelerate_car, brake_car, emergency_brake};
    endfunction

    task automatic check(input string nm, input logic [6:0] got, input logic [6:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got {st,unl,acc,brk,emg}=%b expected %b", nm, got, want);
        end
    endtask

    task automatic drive(input logic e, input logic [6:0] d, input logic [7:0] l,
                         input logic [7:0] s, input logic [2:0] st, input logic u,
                         input string nm);
        exp_t x;
        @(negedge clk);
        enable = e;
        leading_distance = d;
        speed_limit = l;
        car_speed = s;
        x.v = exp_vec(st, u);
        x.name = nm;
        sb_q.push_back(x);
    endtask

    // Pulse rst between edges, check outputs before the next edge, then
    // expect the given result after that edge.
    task automatic rst_pulse(input logic e, input logic [6:0] d, input logic [7:0] l,
                             input logic [7:0] s, input logic [2:0] st, input logic u,
                             input string nm);
        exp_t x;
        @(negedge clk);
        enable = e;
        leading_distance = d;
        speed_limit = l;
        car_speed = s;
        #1 rst = 1'b1;
        #1 check({nm, "_async"}, out_vec(), 7'b0);
        rst = 1'b0;
        x.v = exp_vec(st, u);
        x.name = nm;
        sb_q.push_back(x);
    endtask

    // Monitor: compare after each rising edge when an expectation is pending.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp_t x;
                x = sb_q.pop_front();
                check(x.name, out_vec(), x.v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 check("reset_async", out_vec(), 7'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        //     en  dist  lim   spd   st    unl
        drive(1, 7'd60, 8'd100, 8'd50,  3'd1, 0, "stop_to_accel");
        drive(1, 7'd60, 8'd100, 8'd97,  3'd1, 0, "accel_below_band");
        drive(1, 7'd60, 8'd100, 8'd98,  3'd2, 0, "accel_to_cruise");
        drive(1, 7'd60, 8'd100, 8'd97,  3'd1, 0, "cruise_to_accel");
        drive(1, 7'd60, 8'd100, 8'd101, 3'd3, 0, "accel_overspeed_decel");
        drive(1, 7'd60, 8'd100, 8'd99,  3'd2, 0, "decel_to_cruise");
        drive(1, 7'd9,  8'd100, 8'd99,  3'd4, 0, "cruise_to_emerg");
        drive(1, 7'd80, 8'd100, 8'd30,  3'd4, 0, "emerg_latched_dist");
        drive(0, 7'd80, 8'd100, 8'd30,  3'd4, 0, "emerg_latched_en0");
        drive(0, 7'd80, 8'd100, 8'd0,   3'd0, 0, "emerg_to_stop");
        drive(0, 7'd80, 8'd100, 8'd0,   3'd0, 0, "hold_1");
        drive(0, 7'd80, 8'd100, 8'd0,   3'd0, 0, "hold_2");
        drive(0, 7'd80, 8'd100, 8'd0,   3'd0, 0, "hold_3");
        drive(0, 7'd80, 8'd100, 8'd0,   3'd0, 1, "hold_4_unlock");
        drive(0, 7'd80, 8'd100, 8'd0,   3'd0, 1, "hold_saturate");
        drive(0, 7'd80, 8'd100, 8'd1,   3'd0, 0, "hold_relock");
        drive(0, 7'd80, 8'd100, 8'd0,   3'd0, 0, "rehold_1");
        drive(0, 7'd80, 8'd100, 8'd0,   3'd0, 0, "rehold_2");
        drive(0, 7'd80, 8'd100, 8'd0,   3'd0, 0, "rehold_3");
        drive(0, 7'd80, 8'd100, 8'd1,   3'd0, 0, "rehold_clear");
        drive(1, 7'd60, 8'd1,   8'd0,   3'd1, 0, "lim1_stop_to_accel");
        drive(1, 7'd60, 8'd1,   8'd0,   3'd2, 0, "lim1_accel_to_cruise");
        drive(1, 7'd60, 8'd1,   8'd0,   3'd2, 0, "lim1_cruise_no_wrap");
        drive(1, 7'd60, 8'd1,   8'd1,   3'd2, 0, "lim1_cruise_at_limit");
        drive(1, 7'd39, 8'd1,   8'd1,   3'd3, 0, "dist39_decel");
        drive(1, 7'd40, 8'd1,   8'd1,   3'd2, 0, "dist40_cruise");
        drive(1, 7'd10, 8'd1,   8'd1,   3'd3, 0, "dist10_decel_not_emerg");
        drive(0, 7'd60, 8'd1,   8'd1,   3'd3, 0, "decel_en0_moving");
        drive(0, 7'd60, 8'd1,   8'd0,   3'd0, 0, "decel_en0_to_stop");
        drive(1, 7'd60, 8'd100, 8'd50,  3'd1, 0, "restart_accel");
        drive(1, 7'd60, 8'd100, 8'd120, 3'd3, 0, "overspeed_decel");
        rst_pulse(0, 7'd60, 8'd100, 8'd0, 3'd0, 0, "rst_in_decel");
        drive(0, 7'd60, 8'd100, 8'd0,   3'd0, 0, "post_rst_hold_2");
        drive(0, 7'd60, 8'd100, 8'd0,   3'd0, 0, "post_rst_hold_3");
        drive(0, 7'd60, 8'd100, 8'd0,   3'd0, 1, "post_rst_hold_4");
        drive(1, 7'd60, 8'd100, 8'd50,  3'd1, 0, "accel_again");
        drive(1, 7'd5,  8'd100, 8'd50,  3'd4, 0, "accel_to_emerg");
        rst_pulse(0, 7'd60, 8'd100, 8'd30, 3'd0, 0, "rst_in_emerg");
        drive(0, 7'd60, 8'd100, 8'd30,  3'd0, 0, "stop_moving_locked");

        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adaptive_speed_ctrl.md
ADAPTIVE_SPEED_CTRL -- requirements
Module: adaptive_speed_ctrl

Interface
REQ-001 Parameter SPEED_W, default 8, sets the width of the speed_limit and car_speed ports.
REQ-002 Parameter DIST_W, default 7, sets the width of the leading_distance port.
REQ-003 Parameter MIN_DISTANCE, default 40, is the following distance below which the block decelerates.
REQ-004 Parameter BRAKE_DISTANCE, default 10, is the distance below which emergency braking starts; it is required to be < MIN_DISTANCE.
REQ-005 Parameter HYST, default 2, is the speed band width below speed_limit that counts as "at limit".
REQ-006 Parameter STOP_HOLD_CYCLES, default 4, is the number of consecutive zero-speed cycles in STOP before the doors unlock; it is required to be >= 1.
REQ-007 Ports: clk in 1 system clock; rst in 1 reset.
REQ-008 Ports: enable in 1 driver cruise enable; speed_limit in SPEED_W; car_speed in SPEED_W; leading_distance in DIST_W.
REQ-009 Ports: unlock_doors out 1; accelerate_car out 1; brake_car out 1; emergency_brake out 1; state out 3 (current state code).
REQ-010 There is one clock, clk; rst is asynchronous and active-high.

Function
REQ-011 The FSM has five states, coded: STOP=0, ACCELERATE=1, CRUISE=2, DECELERATE=3, EMERGENCY=4; codes 5-7 go to STOP on the next clk.
REQ-012 The band floor is lo = speed_limit - HYST, saturating at 0, computed without wrap-around; "in band" means lo <= car_speed <= speed_limit.
REQ-013 Priority order in ACCELERATE, CRUISE and DECELERATE:
  - leading_distance < BRAKE_DISTANCE -> EMERGENCY;
  - else enable=0, leading_distance < MIN_DISTANCE, or car_speed > speed_limit -> DECELERATE (DECELERATE with car_speed=0 -> STOP);
  - else state-specific rule.
REQ-014 STOP: enable=1 and leading_distance >= MIN_DISTANCE -> ACCELERATE; otherwise stay.
REQ-015 ACCELERATE: in band -> CRUISE; otherwise stay.
REQ-016 CRUISE: car_speed < lo -> ACCELERATE; otherwise stay.
REQ-017 DECELERATE: car_speed=0 -> STOP; car_speed < lo -> ACCELERATE; in band -> CRUISE.
REQ-018 EMERGENCY is latched: stay until car_speed=0, then STOP, regardless of distance or enable.
REQ-019 hold_cnt increments, saturating at STOP_HOLD_CYCLES, on each clk where cs=STOP and car_speed=0; otherwise it clears to 0.
REQ-020 Outputs are decoded from registered cs and hold_cnt only, with no input-to-output combinational path:
  - accelerate_car = (cs=ACCELERATE);
  - brake_car = (cs=DECELERATE or EMERGENCY);
  - emergency_brake = (cs=EMERGENCY);
  - unlock_doors = (cs=STOP and hold_cnt=STOP_HOLD_CYCLES);
  - state = cs.
REQ-021 Latency: inputs sampled at clk edge N show their effect on the outputs immediately after edge N (one transition per edge).

Reset
REQ-022 On rst=1, cs=STOP and hold_cnt=0 immediately, without waiting for clk, so unlock_doors=0, accelerate_car=0, brake_car=0, emergency_brake=0 and state=0.
REQ-023 rst asserted mid-operation, including in EMERGENCY, aborts to STOP; doors stay locked until STOP_HOLD_CYCLES zero-speed cycles after rst deasserts.

Structure
REQ-024 The state encoding constants and output-decode constants are kept in the shared package adaptive_speed_pkg.
REQ-025 The zero-speed hold counter is the sub-module stop_hold_counter, parameterised by STOP_HOLD_CYCLES; the FSM stays in the top module.

Verification
REQ-026 Reset, then enable=1, dist=60, limit=100, speed=50 for 1 clk -> state=1 and accelerate_car=1.
REQ-027 From ACCELERATE: speed=98 -> CRUISE; speed=97 -> ACCELERATE; speed=101 -> DECELERATE with brake_car=1.
REQ-028 From CRUISE: dist=9 -> EMERGENCY; then dist=80, speed=30 -> stays EMERGENCY; speed=0 -> STOP.
REQ-029 STOP with speed=0 -> unlock_doors=1 exactly on the 4th clk; speed=1 on any cycle clears the count and relocks.
REQ-030 limit=1, HYST=2: lo saturates to 0; speed=0 in CRUISE stays CRUISE (no wrap-around to ACCELERATE).
REQ-031 rst pulsed between clk edges while in DECELERATE -> outputs are all 0 and state=0 before the next edge.
